// File: rtl/vta_read_packer.sv
// vta_read_packer
//
// Feeder for the 128-bit two-port-memory sync queue in the VTA load path.
// It accepts one burst command, then packs consecutive pairs of 64-bit
// read-data beats into 128-bit words. The first beat of a pair lands in
// [63:0] and the second in [127:64]. An odd-length burst ends with a word
// whose upper half is zero. The output side drives the queue's enqueue
// handshake directly. Each accepted beat's last marker is compared with
// the commanded length, and any disagreement raises a sticky error flag.
// Packing always follows the commanded length, never the marker.
//
// Optional feature: define VTA_PACKER_STATS_EN to add io_word_count. It is
// a free-running 32-bit count of output handshakes, cleared only by reset.
//
// Ports:
//   clock, reset       sole clock; synchronous active-high reset
//   io_cmd_ready/valid burst command handshake (ready only when idle)
//   io_cmd_len         beats in burst minus one
//   io_in_ready/valid  read-data beat handshake
//   io_in_bits         64-bit beat
//   io_in_last         source's last-beat marker
//   io_out_ready/valid enqueue handshake toward the queue
//   io_out_bits        packed 128-bit word
//   io_done            one-cycle pulse after the final word of a burst
//   io_err             sticky last-marker mismatch flag
//   io_word_count      (VTA_PACKER_STATS_EN only) output handshake count
module vta_read_packer #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    output logic             io_cmd_ready,
    input  logic             io_cmd_valid,
    input  logic [LEN_W-1:0] io_cmd_len,
    output logic             io_in_ready,
    input  logic             io_in_valid,
    input  logic [63:0]      io_in_bits,
    input  logic             io_in_last,
    input  logic             io_out_ready,
    output logic             io_out_valid,
    output logic [127:0]     io_out_bits,
    output logic             io_done,
    output logic             io_err
`ifdef VTA_PACKER_STATS_EN
    ,
    output logic [31:0]      io_word_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOW   = 2'd1,
        HIGH  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] rem;       // beats left in the burst, minus one
    logic [63:0]      lo;        // first half of the pair being assembled
    logic [127:0]     out_word;
    logic             out_v;
    logic             done_q;
    logic             err_q;

    logic slot_free;
    logic out_fire;
    logic beat_fire;
    logic rem_zero;

    assign out_fire  = out_v & io_out_ready;
    // The slot can take a new word this cycle if it is empty or being dequeued.
    assign slot_free = ~out_v | io_out_ready;
    assign rem_zero  = (rem == '0);
    assign beat_fire = io_in_valid & io_in_ready;

    assign io_cmd_ready = (state == IDLE);
    assign io_out_valid = out_v;
    assign io_out_bits  = out_word;
    assign io_done      = done_q;
    assign io_err       = err_q;

    // A low-half beat never touches the slot, so it is accepted even under
    // back-pressure. Only word-completing beats wait for a free slot.
    always_comb begin
        io_in_ready = 1'b0;
        case (state)
            LOW:     io_in_ready = rem_zero ? slot_free : 1'b1;
            HIGH:    io_in_ready = slot_free;
            default: io_in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            lo       <= '0;
            out_word <= '0;
            out_v    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A load below in the same cycle overrides this clear.
            if (out_fire) begin
                out_v <= 1'b0;
            end

            // The beat should carry last exactly when no beats remain after it.
            if (beat_fire && (io_in_last != rem_zero)) begin
                err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (io_cmd_valid) begin
                        rem   <= io_cmd_len;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (beat_fire) begin
                        if (!rem_zero) begin
                            lo    <= io_in_bits;
                            rem   <= rem - LEN_W'(1);
                            state <= HIGH;
                        end else begin
                            out_word <= {64'h0, io_in_bits};
                            out_v    <= 1'b1;
                            state    <= DRAIN;
                        end
                    end
                end
                HIGH: begin
                    if (beat_fire) begin
                        out_word <= {io_in_bits, lo};
                        out_v    <= 1'b1;
                        if (rem_zero) begin
                            state <= DRAIN;
                        end else begin
                            rem   <= rem - LEN_W'(1);
                            state <= LOW;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef VTA_PACKER_STATS_EN
    logic [31:0] word_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            word_count <= '0;
        end else if (out_fire) begin
            word_count <= word_count + 32'd1;
        end
    end

    assign io_word_count = word_count;
`endif

endmodule

// File: tb/tb_vta_read_packer.sv
// Testbench for vta_read_packer: table of bursts plus hand-written reset
// sequences; expected words are queued as beats are accepted and compared
// when the packer hands them to the queue side.
module tb_vta_read_packer;
    localparam int LEN_W = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic             io_cmd_ready;
    logic             io_cmd_valid;
    logic [LEN_W-1:0] io_cmd_len;
    logic             io_in_ready;
    logic             io_in_valid;
    logic [63:0]      io_in_bits;
    logic             io_in_last;
    logic             io_out_ready;
    logic             io_out_valid;
    logic [127:0]     io_out_bits;
    logic             io_done;
    logic             io_err;
`ifdef VTA_PACKER_STATS_EN
    logic [31:0]      io_word_count;
`endif

    vta_read_packer #(.LEN_W(LEN_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_cmd_ready (io_cmd_ready),
        .io_cmd_valid (io_cmd_valid),
        .io_cmd_len   (io_cmd_len),
        .io_in_ready  (io_in_ready),
        .io_in_valid  (io_in_valid),
        .io_in_bits   (io_in_bits),
        .io_in_last   (io_in_last),
        .io_out_ready (io_out_ready),
        .io_out_valid (io_out_valid),
        .io_out_bits  (io_out_bits),
        .io_done      (io_done),
        .io_err       (io_err)
`ifdef VTA_PACKER_STATS_EN
        ,
        .io_word_count(io_word_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] bits;
        bit           final_w;
        int           stall;
    } exp_t;

    typedef struct {
        int          len;
        logic [63:0] base;
        int          bad_idx;
        int          stall;
        bit          rnd;
        bit          gaps;
        int          exp_words;
        bit          exp_err;
    } vec_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           n_cmp = 0;
    int           n_fail = 0;
    bit           mon_en = 1'b0;
    bit           rnd_ready = 1'b0;
    int           stall_cnt = 0;
    int           burst_words = 0;
    int           total_words = 0;
    bit           done_pend = 1'b0;
    bit           held_v = 1'b0;
    logic [127:0] held;
    vec_t         vec[8];

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Output side: drives io_out_ready, checks words against the scoreboard,
    // hold stability under back-pressure and the done pulse timing.
    always begin
        @(negedge clock);
        if (stall_cnt > 0) begin
            io_out_ready = 1'b0;
            stall_cnt--;
        end else if (rnd_ready) begin
            io_out_ready = ($urandom_range(0, 1) != 0);
        end else begin
            io_out_ready = 1'b1;
        end
        #2;
        if (!mon_en) begin
            done_pend = 1'b0;
            held_v    = 1'b0;
        end else begin
            check1("done_pulse", io_done, done_pend);
            if (done_pend) check1("cmd_ready_after_done", io_cmd_ready, 1'b1);
            done_pend = 1'b0;
            if (held_v) begin
                check1("hold_valid", io_out_valid, 1'b1);
                check128("hold_bits", io_out_bits, held);
            end
            held_v = 1'b0;
            if (io_out_valid && !io_out_ready) begin
                held   = io_out_bits;
                held_v = 1'b1;
            end
            if (io_out_valid && io_out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected no word", io_out_bits);
                end else begin
                    mon_e = sb.pop_front();
                    check128("word", io_out_bits, mon_e.bits);
                    done_pend = mon_e.final_w;
                    stall_cnt = mon_e.stall;
                    burst_words++;
                    total_words++;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the command handshake.
    task automatic send_cmd(input int len);
        int t = 0;
        @(negedge clock);
        io_cmd_valid = 1'b1;
        io_cmd_len   = LEN_W'(len);
        #1;
        while (!io_cmd_ready && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        if (!io_cmd_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cmd_timeout: cmd_ready got 0 expected 1");
        end
        @(negedge clock);
        io_cmd_valid = 1'b0;
        #1;
        check1("cmd_ready_busy", io_cmd_ready, 1'b0);
        @(negedge clock);
    endtask

    // Drives up to max_beats beats of a burst, checking io_in_ready every
    // cycle and queueing each word as its completing beat is accepted.
    task automatic send_beats(input int len, input logic [63:0] base, input int bad_idx,
                              input int stall, input bit gaps, input int max_beats);
        int          idx = 0;
        int          cyc = 0;
        int          lim;
        logic [63:0] lo_m = '0;
        logic [63:0] b;
        logic        exp_rdy;
        exp_t        e;
        lim = (max_beats < len + 1) ? max_beats : len + 1;
        while (idx < lim && cyc < 4000) begin
            b           = base + 64'(idx);
            io_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            io_in_bits  = b;
            io_in_last  = (bad_idx >= 0) ? (idx == bad_idx) : (idx == len);
            #1;
            exp_rdy = ((idx % 2 == 0) && idx != len) ? 1'b1 : (!io_out_valid || io_out_ready);
            check1("in_ready", io_in_ready, exp_rdy);
            if (io_in_valid && io_in_ready) begin
                e.final_w = (idx == len);
                e.stall   = (idx == 1) ? stall : 0;
                if (idx % 2 == 1) begin
                    e.bits = {b, lo_m};
                    sb.push_back(e);
                end else if (idx == len) begin
                    e.bits = {64'h0, b};
                    sb.push_back(e);
                end else begin
                    lo_m = b;
                end
                idx++;
            end
            @(negedge clock);
            cyc++;
        end
        io_in_valid = 1'b0;
        io_in_last  = 1'b0;
        if (idx < lim) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: beats got %0d expected %0d", idx, lim);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0;
        #3;
        rnd_ready   = v.rnd;
        burst_words = 0;
        send_cmd(v.len);
        send_beats(v.len, v.base, v.bad_idx, v.stall, v.gaps, v.len + 1);
        while (sb.size() > 0 && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        repeat (2) @(negedge clock);
        #3;
        rnd_ready = 1'b0;
        check32("queue_left", 32'(sb.size()), 32'd0);
        check32("burst_words", 32'(burst_words), 32'(v.exp_words));
        check1("err_flag", io_err, v.exp_err);
`ifdef VTA_PACKER_STATS_EN
        check32("word_count", io_word_count, 32'(total_words));
`endif
    endtask

    // One-cycle reset from the current point, then checks reset values.
    task automatic do_reset();
        #3;
        mon_en = 1'b0;
        @(negedge clock);
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_cmd_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check1("rst_out_valid", io_out_valid, 1'b0);
        check1("rst_cmd_ready", io_cmd_ready, 1'b1);
        check1("rst_in_ready", io_in_ready, 1'b0);
        check1("rst_done", io_done, 1'b0);
        check1("rst_err", io_err, 1'b0);
        check128("rst_out_bits", io_out_bits, 128'h0);
        #2;
        sb.delete();
        total_words = 0;
        mon_en      = 1'b1;
    endtask

    initial begin
        //          len  base                    bad stall rnd gaps words err
        vec[0] = '{3,   64'hA000_0000_0000_0000, -1, 0,   0,  0,   2,    0};
        vec[1] = '{0,   64'hDEAD_BEEF_0000_0001, -1, 0,   0,  0,   1,    0};
        vec[2] = '{5,   64'hB000_0000_0000_0010, -1, 4,   0,  0,   3,    0};
        vec[3] = '{2,   64'hC000_0000_0000_0020, -1, 0,   0,  1,   2,    0};
        vec[4] = '{255, 64'h1234_5678_0000_0000, -1, 0,   1,  1,   128,  0};
        vec[5] = '{6,   64'hE000_0000_0000_0040, -1, 0,   1,  0,   4,    0};
        vec[6] = '{3,   64'hF000_0000_0000_0050, 1,  0,   0,  0,   2,    1};
        vec[7] = '{1,   64'h7000_0000_0000_0060, -1, 0,   0,  0,   1,    1};

        reset        = 1'b1;
        io_cmd_valid = 1'b0;
        io_cmd_len   = '0;
        io_in_valid  = 1'b0;
        io_in_bits   = '0;
        io_in_last   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check1("init_cmd_ready", io_cmd_ready, 1'b1);
        check1("init_in_ready", io_in_ready, 1'b0);
        check1("init_out_valid", io_out_valid, 1'b0);
        check128("init_out_bits", io_out_bits, 128'h0);
        check1("init_done", io_done, 1'b0);
        check1("init_err", io_err, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #3;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vec[i]);
        end

        // Reset after 3 of 8 beats: partial work discarded, no done pulse.
        #3;
        send_cmd(7);
        send_beats(7, 64'h5000_0000_0000_0070, -1, 0, 0, 3);
        do_reset();
        repeat (3) @(negedge clock);
        run_vec('{1, 64'h6000_0000_0000_0080, -1, 0, 0, 0, 1, 0});

        // Fresh reset, then two bursts totalling four words.
        do_reset();
        run_vec('{3, 64'h8000_0000_0000_0090, -1, 0, 0, 0, 2, 0});
        run_vec('{2, 64'h9000_0000_0000_00A0, -1, 0, 0, 0, 2, 0});
`ifdef VTA_PACKER_STATS_EN
        check32("stats_two_bursts", io_word_count, 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
